// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into HOLD_CYCLES-wide high windows, each followed by a GAP_CYCLES low gap.
// Define PULSE_STRETCH_RETRIGGER_EN for retriggerable monostable mode; the default is queue mode.
module pulse_stretch #(
  parameter int HOLD_CYCLES = 2000000,
  parameter int GAP_CYCLES  = 2000000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_pulse,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [1:0]        dbg_state_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, busy_q;
  logic              start;
  logic              start_taken;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    start_taken = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    start = in_pulse;
`else
    start = in_pulse | (pend_q != '0);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          start_taken = 1'b1;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (in_pulse) begin
          cnt_d = HOLD_LOAD;
        end else
`endif
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Events during the gap are dropped; flag them so the loss is visible.
        if (in_pulse) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        if (cnt_q == '0) begin
          if (start) begin
            state_d     = HOLD;
            cnt_d       = HOLD_LOAD;
            start_taken = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef PULSE_STRETCH_RETRIGGER_EN
    pend_d = '0;
`else
    // An event whose own start is taken this cycle nets out to no change.
    if (in_pulse && !start_taken) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (!in_pulse && start_taken) begin
      pend_d = pend_q - PEND_ONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign pending     = pend_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
